// File: rtl/clint_bus_arbiter.sv
// Two-master AXI4-Lite arbiter in front of the CLINT slave: one whole transaction at a time,
// round-robin grant, and a response watchdog that answers SLVERR when the slave stalls.
module clint_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  // master 0
  input  logic [31:0] i_s0_axi_araddr,
  input  logic        i_s0_axi_arvalid,
  output logic        o_s0_axi_arready,
  output logic [31:0] o_s0_axi_rdata,
  output logic [1:0]  o_s0_axi_rresp,
  output logic        o_s0_axi_rvalid,
  input  logic        i_s0_axi_rready,
  input  logic [31:0] i_s0_axi_awaddr,
  input  logic        i_s0_axi_awvalid,
  output logic        o_s0_axi_awready,
  input  logic [31:0] i_s0_axi_wdata,
  input  logic [3:0]  i_s0_axi_wstrb,
  input  logic        i_s0_axi_wvalid,
  output logic        o_s0_axi_wready,
  output logic [1:0]  o_s0_axi_bresp,
  output logic        o_s0_axi_bvalid,
  input  logic        i_s0_axi_bready,
  // master 1
  input  logic [31:0] i_s1_axi_araddr,
  input  logic        i_s1_axi_arvalid,
  output logic        o_s1_axi_arready,
  output logic [31:0] o_s1_axi_rdata,
  output logic [1:0]  o_s1_axi_rresp,
  output logic        o_s1_axi_rvalid,
  input  logic        i_s1_axi_rready,
  input  logic [31:0] i_s1_axi_awaddr,
  input  logic        i_s1_axi_awvalid,
  output logic        o_s1_axi_awready,
  input  logic [31:0] i_s1_axi_wdata,
  input  logic [3:0]  i_s1_axi_wstrb,
  input  logic        i_s1_axi_wvalid,
  output logic        o_s1_axi_wready,
  output logic [1:0]  o_s1_axi_bresp,
  output logic        o_s1_axi_bvalid,
  input  logic        i_s1_axi_bready,
  // downstream CLINT slave
  output logic [31:0] o_m_axi_araddr,
  output logic        o_m_axi_arvalid,
  input  logic        i_m_axi_arready,
  input  logic [31:0] i_m_axi_rdata,
  input  logic [1:0]  i_m_axi_rresp,
  input  logic        i_m_axi_rvalid,
  output logic        o_m_axi_rready,
  output logic [31:0] o_m_axi_awaddr,
  output logic        o_m_axi_awvalid,
  input  logic        i_m_axi_awready,
  output logic [31:0] o_m_axi_wdata,
  output logic [3:0]  o_m_axi_wstrb,
  output logic        o_m_axi_wvalid,
  input  logic        i_m_axi_wready,
  input  logic [1:0]  i_m_axi_bresp,
  input  logic        i_m_axi_bvalid,
  output logic        o_m_axi_bready
);

  typedef enum logic [2:0] {
    StIdle, StRAddr, StRWait, StRResp, StWAddr, StBWait, StBResp
  } state_e;

  localparam logic [7:0] TmoLim     = 8'(TIMEOUT);
  localparam logic [1:0] RespSlvErr = 2'b10;

  state_e r_state, w_state_nxt;

  logic             r_gnt, w_gnt_nxt;
  logic             r_rr_last, w_rr_last_nxt;
  logic [7:0]       r_cnt, w_cnt_nxt;
  logic [31:0]      r_m_araddr, w_m_araddr_nxt;
  logic             r_m_arvalid, w_m_arvalid_nxt;
  logic             r_m_rready, w_m_rready_nxt;
  logic [31:0]      r_m_awaddr, w_m_awaddr_nxt;
  logic             r_m_awvalid, w_m_awvalid_nxt;
  logic [31:0]      r_m_wdata, w_m_wdata_nxt;
  logic [3:0]       r_m_wstrb, w_m_wstrb_nxt;
  logic             r_m_wvalid, w_m_wvalid_nxt;
  logic             r_m_bready, w_m_bready_nxt;
  logic [1:0]       r_s_arready, w_s_arready_nxt;
  logic [1:0][31:0] r_s_rdata, w_s_rdata_nxt;
  logic [1:0][1:0]  r_s_rresp, w_s_rresp_nxt;
  logic [1:0]       r_s_rvalid, w_s_rvalid_nxt;
  logic [1:0]       r_s_awready, w_s_awready_nxt;
  logic [1:0]       r_s_wready, w_s_wready_nxt;
  logic [1:0][1:0]  r_s_bresp, w_s_bresp_nxt;
  logic [1:0]       r_s_bvalid, w_s_bvalid_nxt;

  logic [1:0][31:0] w_araddr, w_awaddr, w_wdata;
  logic [1:0][3:0]  w_wstrb;
  logic [1:0]       w_rd, w_wr, w_req, w_rready, w_bready;
  logic             w_win, w_win_rd, w_tmo, w_aw_done, w_w_done;
  logic [7:0]       w_cnt_inc;

  assign w_araddr = {i_s1_axi_araddr, i_s0_axi_araddr};
  assign w_awaddr = {i_s1_axi_awaddr, i_s0_axi_awaddr};
  assign w_wdata  = {i_s1_axi_wdata, i_s0_axi_wdata};
  assign w_wstrb  = {i_s1_axi_wstrb, i_s0_axi_wstrb};
  assign w_rready = {i_s1_axi_rready, i_s0_axi_rready};
  assign w_bready = {i_s1_axi_bready, i_s0_axi_bready};
  assign w_rd     = {i_s1_axi_arvalid, i_s0_axi_arvalid};
  assign w_wr     = {i_s1_axi_awvalid & i_s1_axi_wvalid, i_s0_axi_awvalid & i_s0_axi_wvalid};
  assign w_req    = w_rd | w_wr;

  // On a tie the master that did not win last time gets the bus.
  assign w_win     = (&w_req) ? ~r_rr_last : w_req[1];
  assign w_win_rd  = w_rd[w_win];
  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_tmo     = (w_cnt_inc == TmoLim);
  assign w_aw_done = !r_m_awvalid || i_m_axi_awready;
  assign w_w_done  = !r_m_wvalid || i_m_axi_wready;

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (|w_req) w_state_nxt = w_win_rd ? StRAddr : StWAddr;
      StRAddr: if (i_m_axi_arready) w_state_nxt = StRWait;
      StRWait: if (i_m_axi_rvalid || w_tmo) w_state_nxt = StRResp;
      StRResp: if (w_rready[r_gnt]) w_state_nxt = StIdle;
      StWAddr: if (w_aw_done && w_w_done) w_state_nxt = StBWait;
      StBWait: if (i_m_axi_bvalid || w_tmo) w_state_nxt = StBResp;
      StBResp: if (w_bready[r_gnt]) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_gnt_nxt       = r_gnt;
    w_rr_last_nxt   = r_rr_last;
    w_cnt_nxt       = r_cnt;
    w_m_araddr_nxt  = r_m_araddr;
    w_m_arvalid_nxt = r_m_arvalid;
    w_m_rready_nxt  = r_m_rready;
    w_m_awaddr_nxt  = r_m_awaddr;
    w_m_awvalid_nxt = r_m_awvalid;
    w_m_wdata_nxt   = r_m_wdata;
    w_m_wstrb_nxt   = r_m_wstrb;
    w_m_wvalid_nxt  = r_m_wvalid;
    w_m_bready_nxt  = r_m_bready;
    w_s_rdata_nxt   = r_s_rdata;
    w_s_rresp_nxt   = r_s_rresp;
    w_s_rvalid_nxt  = r_s_rvalid;
    w_s_bresp_nxt   = r_s_bresp;
    w_s_bvalid_nxt  = r_s_bvalid;
    // Upstream address/data readies are single-cycle pulses.
    w_s_arready_nxt = 2'b00;
    w_s_awready_nxt = 2'b00;
    w_s_wready_nxt  = 2'b00;
    unique case (r_state)
      StIdle: begin
        if (|w_req) begin
          w_gnt_nxt     = w_win;
          w_rr_last_nxt = w_win;
          if (w_win_rd) begin
            w_m_araddr_nxt         = w_araddr[w_win];
            w_m_arvalid_nxt        = 1'b1;
            w_s_arready_nxt[w_win] = 1'b1;
          end else begin
            w_m_awaddr_nxt         = w_awaddr[w_win];
            w_m_wdata_nxt          = w_wdata[w_win];
            w_m_wstrb_nxt          = w_wstrb[w_win];
            w_m_awvalid_nxt        = 1'b1;
            w_m_wvalid_nxt         = 1'b1;
            w_s_awready_nxt[w_win] = 1'b1;
            w_s_wready_nxt[w_win]  = 1'b1;
          end
        end
      end
      StRAddr: begin
        if (i_m_axi_arready) begin
          w_m_arvalid_nxt = 1'b0;
          w_m_rready_nxt  = 1'b1;
          w_cnt_nxt       = 8'd0;
        end
      end
      StRWait: begin
        if (i_m_axi_rvalid) begin
          w_s_rdata_nxt[r_gnt]  = i_m_axi_rdata;
          w_s_rresp_nxt[r_gnt]  = i_m_axi_rresp;
          w_s_rvalid_nxt[r_gnt] = 1'b1;
          w_m_rready_nxt        = 1'b0;
        end else if (w_tmo) begin
          w_s_rdata_nxt[r_gnt]  = 32'd0;
          w_s_rresp_nxt[r_gnt]  = RespSlvErr;
          w_s_rvalid_nxt[r_gnt] = 1'b1;
          w_m_rready_nxt        = 1'b0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      StRResp: if (w_rready[r_gnt]) w_s_rvalid_nxt[r_gnt] = 1'b0;
      StWAddr: begin
        if (i_m_axi_awready) w_m_awvalid_nxt = 1'b0;
        if (i_m_axi_wready)  w_m_wvalid_nxt  = 1'b0;
        if (w_aw_done && w_w_done) begin
          w_m_bready_nxt = 1'b1;
          w_cnt_nxt      = 8'd0;
        end
      end
      StBWait: begin
        if (i_m_axi_bvalid) begin
          w_s_bresp_nxt[r_gnt]  = i_m_axi_bresp;
          w_s_bvalid_nxt[r_gnt] = 1'b1;
          w_m_bready_nxt        = 1'b0;
        end else if (w_tmo) begin
          w_s_bresp_nxt[r_gnt]  = RespSlvErr;
          w_s_bvalid_nxt[r_gnt] = 1'b1;
          w_m_bready_nxt        = 1'b0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      StBResp: if (w_bready[r_gnt]) w_s_bvalid_nxt[r_gnt] = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_gnt       <= 1'b0;
      r_rr_last   <= 1'b1;
      r_cnt       <= 8'd0;
      r_m_araddr  <= '0;
      r_m_arvalid <= 1'b0;
      r_m_rready  <= 1'b0;
      r_m_awaddr  <= '0;
      r_m_awvalid <= 1'b0;
      r_m_wdata   <= '0;
      r_m_wstrb   <= '0;
      r_m_wvalid  <= 1'b0;
      r_m_bready  <= 1'b0;
      r_s_arready <= '0;
      r_s_rdata   <= '0;
      r_s_rresp   <= '0;
      r_s_rvalid  <= '0;
      r_s_awready <= '0;
      r_s_wready  <= '0;
      r_s_bresp   <= '0;
      r_s_bvalid  <= '0;
    end else begin
      r_gnt       <= w_gnt_nxt;
      r_rr_last   <= w_rr_last_nxt;
      r_cnt       <= w_cnt_nxt;
      r_m_araddr  <= w_m_araddr_nxt;
      r_m_arvalid <= w_m_arvalid_nxt;
      r_m_rready  <= w_m_rready_nxt;
      r_m_awaddr  <= w_m_awaddr_nxt;
      r_m_awvalid <= w_m_awvalid_nxt;
      r_m_wdata   <= w_m_wdata_nxt;
      r_m_wstrb   <= w_m_wstrb_nxt;
      r_m_wvalid  <= w_m_wvalid_nxt;
      r_m_bready  <= w_m_bready_nxt;
      r_s_arready <= w_s_arready_nxt;
      r_s_rdata   <= w_s_rdata_nxt;
      r_s_rresp   <= w_s_rresp_nxt;
      r_s_rvalid  <= w_s_rvalid_nxt;
      r_s_awready <= w_s_awready_nxt;
      r_s_wready  <= w_s_wready_nxt;
      r_s_bresp   <= w_s_bresp_nxt;
      r_s_bvalid  <= w_s_bvalid_nxt;
    end
  end

  assign o_s0_axi_arready = r_s_arready[0];
  assign o_s0_axi_rdata   = r_s_rdata[0];
  assign o_s0_axi_rresp   = r_s_rresp[0];
  assign o_s0_axi_rvalid  = r_s_rvalid[0];
  assign o_s0_axi_awready = r_s_awready[0];
  assign o_s0_axi_wready  = r_s_wready[0];
  assign o_s0_axi_bresp   = r_s_bresp[0];
  assign o_s0_axi_bvalid  = r_s_bvalid[0];

  assign o_s1_axi_arready = r_s_arready[1];
  assign o_s1_axi_rdata   = r_s_rdata[1];
  assign o_s1_axi_rresp   = r_s_rresp[1];
  assign o_s1_axi_rvalid  = r_s_rvalid[1];
  assign o_s1_axi_awready = r_s_awready[1];
  assign o_s1_axi_wready  = r_s_wready[1];
  assign o_s1_axi_bresp   = r_s_bresp[1];
  assign o_s1_axi_bvalid  = r_s_bvalid[1];

  assign o_m_axi_araddr   = r_m_araddr;
  assign o_m_axi_arvalid  = r_m_arvalid;
  assign o_m_axi_rready   = r_m_rready;
  assign o_m_axi_awaddr   = r_m_awaddr;
  assign o_m_axi_awvalid  = r_m_awvalid;
  assign o_m_axi_wdata    = r_m_wdata;
  assign o_m_axi_wstrb    = r_m_wstrb;
  assign o_m_axi_wvalid   = r_m_wvalid;
  assign o_m_axi_bready   = r_m_bready;

endmodule
